// File: rtl/pts_stream_serializer.sv
// Frame-in / beat-out serializer for FFT results: a shadow register takes the
// next frame while the active register streams LANES words per beat.
module pts_stream_serializer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int LANES  = 1,
  parameter int BITREV = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [DEPTH*DATA_W-1:0]   par_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_last
);

  localparam int BEATS = DEPTH / LANES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic              shadow_full;
  logic [BW-1:0]     beat;
  logic [DATA_W-1:0] shadow_mem [DEPTH];
  logic [DATA_W-1:0] active_mem [DEPTH];

  logic last_beat;
  logic beat_acc;
  logic transfer;
  logic load_acc;

  // Output word index: identity, or reversed over log2(DEPTH) bits.
  function automatic logic [AW-1:0] word_idx(input logic [AW-1:0] i);
    logic [AW-1:0] r;
    r = i;
    if (BITREV != 0) begin
      for (int b = 0; b < AW; b++) r[b] = i[AW-1-b];
    end
    return r;
  endfunction

  assign last_beat = (beat == LAST_BEAT);
  assign beat_acc  = (state == SHIFT) && out_ready;
  // A waiting frame moves up when idle or as the final beat leaves.
  assign transfer  = shadow_full && ((state == IDLE) || (beat_acc && last_beat));
  assign load_acc  = load_valid && !shadow_full;

  // Shadow capture, shadow-to-active transfer and beat sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shadow_full <= 1'b0;
      beat        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        shadow_mem[i] <= '0;
        active_mem[i] <= '0;
      end
    end else begin
      if (load_acc) begin
        for (int i = 0; i < DEPTH; i++) shadow_mem[i] <= par_in[i*DATA_W +: DATA_W];
        shadow_full <= 1'b1;
      end
      if (transfer) begin
        for (int i = 0; i < DEPTH; i++) active_mem[i] <= shadow_mem[i];
        beat        <= '0;
        state       <= SHIFT;
        shadow_full <= 1'b0;
      end else if (beat_acc) begin
        if (last_beat) begin
          state <= IDLE;
          beat  <= '0;
        end else begin
          beat <= beat + BW'(1);
        end
      end
    end
  end

  // Output beat is a pure function of registered state.
  always_comb begin
    out_data = '0;
    if (state == SHIFT) begin
      for (int k = 0; k < LANES; k++) begin
        out_data[k*DATA_W +: DATA_W] = active_mem[word_idx(AW'(int'(beat) * LANES + k))];
      end
    end
  end

  assign out_valid  = (state == SHIFT);
  assign out_last   = (state == SHIFT) && last_beat;
  assign load_ready = !shadow_full;

endmodule

// File: tb/tb_pts_stream_serializer.sv
// Bench for pts_stream_serializer: natural, bit-reversed and 4-lane instances
// share stimulus; a per-instance queue holds the expected beats.
module tb_pts_stream_serializer;

  localparam int DW  = 16;
  localparam int DEP = 32;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int          sel;
    int          beat;
    logic [63:0] data;
    logic        last;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               out_ready;
  logic [DEP*DW-1:0]  par_in;
  logic               lv [3];
  logic               lr [3];
  logic               ov [3];
  logic               ol [3];
  logic [15:0]        od_n;
  logic [15:0]        od_r;
  logic [63:0]        od_4;
  logic [63:0]        od [3];

  assign od[0] = {48'h0, od_n};
  assign od[1] = {48'h0, od_r};
  assign od[2] = od_4;

  pts_stream_serializer #(.DATA_W(DW), .DEPTH(DEP), .LANES(1), .BITREV(0)) u_nat (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]), .par_in(par_in),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od_n), .out_last(ol[0]));

  pts_stream_serializer #(.DATA_W(DW), .DEPTH(DEP), .LANES(1), .BITREV(1)) u_rev (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]), .par_in(par_in),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od_r), .out_last(ol[1]));

  pts_stream_serializer #(.DATA_W(DW), .DEPTH(DEP), .LANES(4), .BITREV(0)) u_l4 (
    .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(lr[2]), .par_in(par_in),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od_4), .out_last(ol[2]));

  int          checks = 0;
  int          errors = 0;
  exp_t        sbq [3][$];
  logic [64:0] cap [3][64];
  int          cap_n [3];
  bit          cap_en = 1'b0;
  int          acc_cnt [3];
  bit          hold_chk [3];
  logic [63:0] hd [3];
  logic        hl [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DEP*DW-1:0] mk_frame(input logic [15:0] base);
    logic [DEP*DW-1:0] f;
    for (int i = 0; i < DEP; i++) f[i*DW +: DW] = base + 16'(i);
    return f;
  endfunction

  // Expected beats of the frame currently on par_in for instance i.
  task automatic push_frame(input int i);
    int          nl;
    int          nb;
    int          w;
    int          idx;
    logic [4:0]  w5;
    exp_t        e;
    nl = (i == 2) ? 4 : 1;
    nb = DEP / nl;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int k = 0; k < nl; k++) begin
        w  = b * nl + k;
        w5 = w[4:0];
        idx = (i == 1) ? int'({w5[0], w5[1], w5[2], w5[3], w5[4]}) : w;
        e.data[k*16 +: 16] = par_in[idx*16 +: 16];
      end
      e.last = (b == nb - 1);
      sbq[i].push_back(e);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) sbq[i].delete();
    end
  end

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        hold_chk[i] = 1'b0;
      end else begin
        if (lv[i] && lr[i]) push_frame(i);
        if (hold_chk[i] && ov[i]) begin
          chk($sformatf("stall_hold_data[%0d]", i), od[i], hd[i]);
          chk($sformatf("stall_hold_last[%0d]", i), 64'(ol[i]), 64'(hl[i]));
        end
        hold_chk[i] = ov[i] && !out_ready;
        hd[i] = od[i];
        hl[i] = ol[i];
        if (!ov[i]) chk($sformatf("idle_data_zero[%0d]", i), od[i], 64'h0);
        if (ov[i] && out_ready) begin
          if (sbq[i].size() == 0) begin
            chk($sformatf("unexpected_beat[%0d]", i), 64'(ov[i]), 64'h0);
          end else begin
            e = sbq[i].pop_front();
            chk($sformatf("beat_data[%0d]", i), od[i], e.data);
            chk($sformatf("beat_last[%0d]", i), 64'(ol[i]), 64'(e.last));
          end
          if (cap_en && cap_n[i] < 64) begin
            cap[i][cap_n[i]] = {ol[i], od[i]};
            cap_n[i]++;
          end
          acc_cnt[i]++;
        end
      end
    end
  end

  task automatic load_frame(input logic [2:0] mask, input logic [15:0] base);
    bit ok;
    ok = 1'b0;
    par_in = mk_frame(base);
    for (int i = 0; i < 3; i++) lv[i] = mask[i];
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((!mask[0] || lr[0]) && (!mask[1] || lr[1]) && (!mask[2] || lr[2])) begin
        ok = 1'b1;
        break;
      end
    end
    chk("load_accept_in_budget", 64'(ok), 64'h1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) lv[i] = 1'b0;
  endtask

  task automatic drain(input int budget, input bit toggle);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      if (toggle) out_ready = !out_ready;
      if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0 &&
          !ov[0] && !ov[1] && !ov[2]) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    chk("drain_in_budget", 64'(ok), 64'h1);
  endtask

  task automatic wait_beat(input logic [15:0] val, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ov[0] && od[0] == 64'(val)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t vt [15];
    vt[0]  = '{0, 0,  64'h0100, 1'b0};
    vt[1]  = '{0, 1,  64'h0101, 1'b0};
    vt[2]  = '{0, 30, 64'h011E, 1'b0};
    vt[3]  = '{0, 31, 64'h011F, 1'b1};
    vt[4]  = '{1, 0,  64'h0100, 1'b0};
    vt[5]  = '{1, 1,  64'h0110, 1'b0};
    vt[6]  = '{1, 2,  64'h0108, 1'b0};
    vt[7]  = '{1, 3,  64'h0118, 1'b0};
    vt[8]  = '{1, 4,  64'h0104, 1'b0};
    vt[9]  = '{1, 30, 64'h010F, 1'b0};
    vt[10] = '{1, 31, 64'h011F, 1'b1};
    vt[11] = '{2, 0,  64'h0103_0102_0101_0100, 1'b0};
    vt[12] = '{2, 1,  64'h0107_0106_0105_0104, 1'b0};
    vt[13] = '{2, 6,  64'h011B_011A_0119_0118, 1'b0};
    vt[14] = '{2, 7,  64'h011F_011E_011D_011C, 1'b1};

    rst = 1'b1;
    out_ready = 1'b1;
    par_in = '0;
    for (int i = 0; i < 3; i++) begin
      lv[i] = 1'b0;
      cap_n[i] = 0;
      acc_cnt[i] = 0;
    end

    // Reset state and its persistence with no load.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(ov[0]), 64'h0);
    chk("rst_out_data", od[0], 64'h0);
    chk("rst_out_last", 64'(ol[0]), 64'h0);
    chk("rst_load_ready", 64'(lr[0]), 64'h1);
    chk("rst_load_ready_l4", 64'(lr[2]), 64'h1);
    @(posedge clk);
    #1;
    chk("idle_out_valid", 64'(ov[0]), 64'h0);
    chk("idle_out_data", od[0], 64'h0);
    chk("idle_load_ready", 64'(lr[0]), 64'h1);

    // One frame into all three instances; latency and ordering.
    cap_en = 1'b1;
    load_frame(3'b111, 16'h0100);
    chk("lat_valid_edge_n", 64'(ov[0]), 64'h0);
    chk("lat_ready_after_load", 64'(lr[0]), 64'h0);
    @(posedge clk);
    #1;
    chk("lat_valid_nat", 64'(ov[0]), 64'h1);
    chk("lat_valid_rev", 64'(ov[1]), 64'h1);
    chk("lat_valid_l4", 64'(ov[2]), 64'h1);
    chk("lat_first_data", od[0], 64'h0100);
    chk("lat_ready_after_xfer", 64'(lr[0]), 64'h1);
    drain(300, 1'b0);
    cap_en = 1'b0;
    chk("valid_low_after_frame", 64'(ov[0]), 64'h0);
    chk("beats_nat", 64'(cap_n[0]), 64'd32);
    chk("beats_rev", 64'(cap_n[1]), 64'd32);
    chk("beats_l4", 64'(cap_n[2]), 64'd8);
    for (int v = 0; v < 15; v++) begin
      chk($sformatf("vec%0d_data", v), cap[vt[v].sel][vt[v].beat][63:0], vt[v].data);
      chk($sformatf("vec%0d_last", v), 64'(cap[vt[v].sel][vt[v].beat][64]), 64'(vt[v].last));
    end

    // Back-to-back frames A, B and a held third load C.
    load_frame(3'b001, 16'h0100);
    load_frame(3'b001, 16'h0200);
    par_in = mk_frame(16'h0300);
    lv[0] = 1'b1;
    chk("ready_low_while_b_waits", 64'(lr[0]), 64'h0);
    wait_beat(16'h011F, "found_a_last");
    chk("ready_low_at_a_last", 64'(lr[0]), 64'h0);
    chk("a_last_flag", 64'(ol[0]), 64'h1);
    @(posedge clk);
    #1;
    chk("b2b_no_bubble", 64'(ov[0]), 64'h1);
    chk("b2b_b_first", od[0], 64'h0200);
    chk("ready_back_after_a", 64'(lr[0]), 64'h1);
    @(posedge clk);
    #1;
    chk("c_accepted", 64'(lr[0]), 64'h0);
    lv[0] = 1'b0;
    drain(400, 1'b0);

    // Backpressure with out_ready toggling every cycle.
    acc_cnt[0] = 0;
    load_frame(3'b001, 16'h0400);
    drain(300, 1'b1);
    chk("bp_beat_count", 64'(acc_cnt[0]), 64'd32);

    // Reset in the middle of a frame.
    load_frame(3'b001, 16'h0500);
    wait_beat(16'h050A, "found_beat10");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", 64'(ov[0]), 64'h0);
    chk("midrst_load_ready", 64'(lr[0]), 64'h1);
    chk("midrst_out_data", od[0], 64'h0);
    chk("midrst_out_last", 64'(ol[0]), 64'h0);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      chk("no_residual_beat", 64'(ov[0]), 64'h0);
    end

    // Recovery with a fresh frame.
    acc_cnt[0] = 0;
    load_frame(3'b001, 16'h0600);
    drain(300, 1'b0);
    chk("recovery_beat_count", 64'(acc_cnt[0]), 64'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
